cpu_test_monitor: RTL

- Synthesizable run-control monitor instantiated beside `cpu` in benches and FPGA bring-up builds.
- Watches the retire stream and data-memory store bus, and decides test outcome in hardware: PASS, FAIL or TIMEOUT.
- Counts cycles and retired instructions, and latches the end PC, so the bench only samples a done flag.
- Generalises end-of-test detection: configurable widths, sentinel opcode, status address and codes, timeout, and retire-valid qualification for multi-cycle cores.

---
 rtl/cpu_test_monitor_if.sv | 39 +++
 rtl/cpu_test_monitor.sv | 123 ++++++++++++
 2 files changed

// File: rtl/cpu_test_monitor_if.sv
// cpu_test_monitor_if: retire/store observation bus and run-control results for cpu_test_monitor.
`default_nettype none

interface cpu_test_monitor_if #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 32
);
  logic                 en;
  logic                 instr_valid;
  logic [XLEN-1:0]      debug_pc;
  logic [XLEN-1:0]      instr;
  logic                 mem_write;
  logic [XLEN-1:0]      dmem_addr;
  logic [XLEN-1:0]      store_data;
  logic                 done;
  logic                 pass;
  logic                 fail;
  logic                 timeout;
  logic                 status_ok;
  logic [CNT_WIDTH-1:0] cycle_count;
  logic [CNT_WIDTH-1:0] instr_count;
  logic [XLEN-1:0]      end_pc;
  logic [XLEN-1:0]      fail_code;
  logic [7:0]           misalign_count;

  modport master (
    output en, instr_valid, debug_pc, instr, mem_write, dmem_addr, store_data,
    input  done, pass, fail, timeout, status_ok, cycle_count, instr_count,
           end_pc, fail_code, misalign_count
  );

  modport slave (
    input  en, instr_valid, debug_pc, instr, mem_write, dmem_addr, store_data,
    output done, pass, fail, timeout, status_ok, cycle_count, instr_count,
           end_pc, fail_code, misalign_count
  );
endinterface

`default_nettype wire

// File: rtl/cpu_test_monitor.sv
// cpu_test_monitor: decides PASS/FAIL/TIMEOUT from retire and store streams.
// Optional macro CPU_TEST_MONITOR_MISALIGN_TRAP_EN makes the first misaligned store a failure.
`default_nettype none

module cpu_test_monitor #(
  parameter int              XLEN          = 32,
  parameter int              CNT_WIDTH     = 32,
  parameter int              MAX_CYCLES    = 20,
  parameter logic [XLEN-1:0] END_SENTINEL  = 32'h0000_006F,
  parameter int              SENTINEL_HITS = 2,
  parameter logic [XLEN-1:0] STATUS_ADDR   = 32'h0000_0000,
  parameter logic [XLEN-1:0] STATUS_PASS   = 32'hC0DE_CAFE,
  parameter logic [XLEN-1:0] STATUS_FAIL   = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              reset,
  cpu_test_monitor_if.slave bus
);

  localparam int HIT_W = $clog2(SENTINEL_HITS + 1) + 1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RUN     = 3'd1;
  localparam logic [2:0] ST_PASS    = 3'd2;
  localparam logic [2:0] ST_FAIL    = 3'd3;
  localparam logic [2:0] ST_TIMEOUT = 3'd4;

  logic [2:0]           state, state_next;
  logic [HIT_W-1:0]     hit_cnt;
  logic [CNT_WIDTH-1:0] cycle_count, instr_count;
  logic [XLEN-1:0]      end_pc, fail_code;
  logic [7:0]           misalign_count;
  logic                 status_ok;
  logic                 done_o, pass_o, fail_o, timeout_o;

  logic status_store, pass_store, bad_store, misaligned, trap;
  logic is_sentinel, sentinel_done, timeout_hit, fail_event;

  assign misaligned   = bus.mem_write && (bus.dmem_addr[1:0] != 2'b00);
  assign status_store = bus.mem_write && !misaligned && (bus.dmem_addr == STATUS_ADDR);
  assign pass_store   = status_store && (bus.store_data == STATUS_PASS);
  // Any non-PASS code fails; STATUS_FAIL is informational only.
  assign bad_store    = status_store && (bus.store_data != STATUS_PASS);

`ifdef CPU_TEST_MONITOR_MISALIGN_TRAP_EN
  assign trap = misaligned;
`else
  assign trap = 1'b0;
`endif

  assign is_sentinel   = bus.instr_valid && (bus.instr == END_SENTINEL);
  assign sentinel_done = is_sentinel && (hit_cnt == HIT_W'(SENTINEL_HITS - 1));
  assign timeout_hit   = (cycle_count == CNT_WIDTH'(MAX_CYCLES - 1));
  assign fail_event    = bad_store || trap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (bus.en) state_next = ST_RUN;
      ST_RUN: begin
        if (fail_event)         state_next = ST_FAIL;
        else if (sentinel_done) state_next = (status_ok || pass_store) ? ST_PASS : ST_FAIL;
        else if (timeout_hit)   state_next = ST_TIMEOUT;
      end
      ST_PASS, ST_FAIL, ST_TIMEOUT: state_next = state;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    done_o    = 1'b0;
    pass_o    = 1'b0;
    fail_o    = 1'b0;
    timeout_o = 1'b0;
    case (state)
      ST_PASS:    begin done_o = 1'b1; pass_o = 1'b1; end
      ST_FAIL:    begin done_o = 1'b1; fail_o = 1'b1; end
      ST_TIMEOUT: begin done_o = 1'b1; fail_o = 1'b1; timeout_o = 1'b1; end
      default:    ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count    <= '0;
      instr_count    <= '0;
      hit_cnt        <= '0;
      end_pc         <= '0;
      fail_code      <= '0;
      misalign_count <= '0;
      status_ok      <= 1'b0;
    end else if (state == ST_RUN) begin
      if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
      if (bus.instr_valid && instr_count != '1) instr_count <= instr_count + 1'b1;
      if (bus.instr_valid) hit_cnt <= is_sentinel ? hit_cnt + 1'b1 : '0;
      if (misaligned && misalign_count != 8'hFF) misalign_count <= misalign_count + 8'd1;
      if (pass_store) status_ok <= 1'b1;
      if (bad_store)  fail_code <= bus.store_data;
      else if (trap)  fail_code <= bus.dmem_addr;
      // end_pc records only a sentinel that actually terminates the run.
      if (sentinel_done && !fail_event) end_pc <= bus.debug_pc;
    end
  end

  assign bus.done           = done_o;
  assign bus.pass           = pass_o;
  assign bus.fail           = fail_o;
  assign bus.timeout        = timeout_o;
  assign bus.status_ok      = status_ok;
  assign bus.cycle_count    = cycle_count;
  assign bus.instr_count    = instr_count;
  assign bus.end_pc         = end_pc;
  assign bus.fail_code      = fail_code;
  assign bus.misalign_count = misalign_count;

endmodule

`default_nettype wire
